ddr2_cmd_scheduler: RTL and testbench

Sits between the AXI front-end of the DDR2 AXI controller and the DDR2 command engine. It takes single-beat read and write requests, plus refresh obligations from an internal tREFI timer, and decides which one reaches the command engine next. The command engine accepts exactly one command at a time. The scheduler enforces read/write fairness, refresh priority with up to 8 postponed refreshes, and tRFC spacing.

---
 rtl/ddr2_sched_pkg.sv | 17 +
 rtl/ddr2_refresh_timer.sv | 43 ++++
 rtl/ddr2_cmd_scheduler.sv | 117 +++++++++++
 tb/tb_ddr2_cmd_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_sched_pkg.sv
// ddr2_sched_pkg: shared command encodings, FSM states and refresh limits for the DDR2 scheduler
package ddr2_sched_pkg;
    typedef enum logic [1:0] {
        CMD_NOP = 2'b00,
        CMD_WR  = 2'b01,
        CMD_RD  = 2'b10,
        CMD_REF = 2'b11
    } cmd_type_e;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_REF_WAIT
    } state_e;
    localparam int REF_OWED_MAX = 8;
    localparam int REF_URGENT   = 4;
endpackage

// File: rtl/ddr2_refresh_timer.sv
// ddr2_refresh_timer: tREFI obligation timer with saturating owed-refresh count and sticky overflow
module ddr2_refresh_timer
    import ddr2_sched_pkg::*;
#(
    parameter int REFI_CYCLES = 780
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       init_done_i,
    input  logic       ref_accept_i,
    output logic [3:0] ref_owed_o,
    output logic       ref_overflow_o
);
    localparam int CW = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    owed_q, owed_d;
    logic          ovf_q, ovf_d;
    logic          wrap;
    logic          full;
    // a wrap and an acceptance in the same cycle cancel; a wrap with no room left trips overflow
    always_comb begin
        wrap   = init_done_i && (cnt_q == CW'(REFI_CYCLES - 1));
        full   = owed_q == 4'(REF_OWED_MAX);
        cnt_d  = !init_done_i ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
        owed_d = (wrap && !ref_accept_i) ? (full ? owed_q : owed_q + 4'd1) :
                 (!wrap && ref_accept_i && owed_q != 4'd0) ? owed_q - 4'd1 : owed_q;
        ovf_d  = ovf_q | (wrap && !ref_accept_i && full);
    end
    // timer, owed count and sticky overflow registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            owed_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            owed_q <= owed_d;
            ovf_q  <= ovf_d;
        end
    end
    assign ref_owed_o     = owed_q;
    assign ref_overflow_o = ovf_q;
endmodule

// File: rtl/ddr2_cmd_scheduler.sv
// ddr2_cmd_scheduler: arbitrates reads, writes and refreshes into a one-at-a-time DDR2 command engine
module ddr2_cmd_scheduler
    import ddr2_sched_pkg::*;
#(
    parameter int ADDR_WIDTH  = 28,
    parameter int REFI_CYCLES = 780,
    parameter int RFC_CYCLES  = 13,
    parameter int MAX_STREAK  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  init_done,
    input  logic                  wr_req_valid,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    output logic                  wr_req_ready,
    input  logic                  rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_req_ready,
    output logic                  cmd_valid,
    output logic [1:0]            cmd_type,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_ready,
    input  logic                  cmd_done,
    output logic [3:0]            ref_owed,
    output logic                  ref_overflow,
    output logic                  busy
);
    localparam int RW = $clog2(RFC_CYCLES + 1);
    localparam int SW = $clog2(MAX_STREAK + 1);
    state_e                state_q, state_d;
    cmd_type_e             type_q, type_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RW-1:0]         rfc_q, rfc_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  last_rd_q, last_rd_d;
    logic                  ref_accept;
    logic                  can_grant, urgent, pick_rd, grant_req, grant_ref;
    ddr2_refresh_timer #(.REFI_CYCLES(REFI_CYCLES)) u_refresh_timer (
        .clk_i          (ACLK),
        .rst_i          (ARESET),
        .init_done_i    (init_done),
        .ref_accept_i   (ref_accept),
        .ref_owed_o     (ref_owed),
        .ref_overflow_o (ref_overflow)
    );
    // IDLE arbitration: urgent refresh, then requests with streak-limited fairness, then lazy refresh
    always_comb begin
        can_grant    = (state_q == ST_IDLE) && init_done;
        urgent       = ref_owed >= 4'(REF_URGENT);
        pick_rd      = (rd_req_valid && wr_req_valid) ? (last_rd_q ^ (streak_q == SW'(MAX_STREAK))) : rd_req_valid;
        grant_req    = can_grant && !urgent && (rd_req_valid || wr_req_valid);
        grant_ref    = can_grant && (urgent || (!rd_req_valid && !wr_req_valid && ref_owed != 4'd0));
        rd_req_ready = grant_req && pick_rd;
        wr_req_ready = grant_req && !pick_rd;
    end
    // next-state logic: latch grants, hold commands until accepted, enforce tRFC idle after REF
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        rfc_d      = rfc_q;
        streak_d   = streak_q;
        last_rd_d  = last_rd_q;
        ref_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_req) begin
                    state_d   = ST_ISSUE;
                    type_d    = pick_rd ? CMD_RD : CMD_WR;
                    addr_d    = pick_rd ? rd_req_addr : wr_req_addr;
                    streak_d  = (pick_rd != last_rd_q) ? SW'(1) :
                                (streak_q == SW'(MAX_STREAK)) ? streak_q : streak_q + 1'b1;
                    last_rd_d = pick_rd;
                end else if (grant_ref) begin
                    state_d = ST_ISSUE;
                    type_d  = CMD_REF;
                    addr_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    ref_accept = type_q == CMD_REF;
                    state_d    = (type_q == CMD_REF) ? ST_REF_WAIT : ST_WAIT_DONE;
                    rfc_d      = (type_q == CMD_REF) ? RW'(RFC_CYCLES) : rfc_q;
                end
            end
            ST_WAIT_DONE: state_d = cmd_done ? ST_IDLE : ST_WAIT_DONE;
            ST_REF_WAIT: begin
                rfc_d   = rfc_q - 1'b1;
                state_d = (rfc_q <= RW'(1)) ? ST_IDLE : ST_REF_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // state and command registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            type_q    <= CMD_NOP;
            addr_q    <= '0;
            rfc_q     <= '0;
            streak_q  <= '0;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            rfc_q     <= rfc_d;
            streak_q  <= streak_d;
            last_rd_q <= last_rd_d;
        end
    end
    assign cmd_valid = state_q == ST_ISSUE;
    assign cmd_type  = type_q;
    assign cmd_addr  = addr_q;
    assign busy      = state_q != ST_IDLE;
endmodule

// File: tb/tb_ddr2_cmd_scheduler.sv
// tb_ddr2_cmd_scheduler: directed vector table plus multi-cycle sequences for the DDR2 command scheduler
module tb_ddr2_cmd_scheduler;
    localparam int AW = 28;
    logic          clk = 1'b0;
    logic          ARESET, init_done;
    logic          wr_req_valid, rd_req_valid, wr_req_ready, rd_req_ready;
    logic [AW-1:0] wr_req_addr, rd_req_addr, cmd_addr;
    logic          cmd_valid, cmd_ready, cmd_done, ref_overflow, busy;
    logic [1:0]    cmd_type;
    logic [3:0]    ref_owed;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            eng_en = 1'b1;
    byte           grants[$];
    typedef struct {
        bit          is_rd;
        logic [AW-1:0] addr;
        logic [1:0]  etype;
        logic [AW-1:0] eaddr;
    } vec_t;
    vec_t vecs[6];

    ddr2_cmd_scheduler #(
        .ADDR_WIDTH(AW), .REFI_CYCLES(100), .RFC_CYCLES(5), .MAX_STREAK(4)
    ) dut (
        .ACLK(clk), .ARESET(ARESET), .init_done(init_done),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_ready(wr_req_ready),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .ref_owed(ref_owed), .ref_overflow(ref_overflow), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_req_valid && rd_req_ready) grants.push_back("R");
        if (wr_req_valid && wr_req_ready) grants.push_back("W");
        if (rd_req_ready && wr_req_ready) begin
            total++;
            bad++;
            $display("FAIL both_ready: rd=1 wr=1 at cycle %0d, required at most one", cyc);
        end
    end

    // engine model: ready two cycles into cmd_valid, done three cycles after a WR/RD acceptance
    initial begin
        int vcnt, dcnt;
        logic [1:0] acc_t;
        vcnt = 0; dcnt = 0; acc_t = 2'b00;
        cmd_ready = 1'b0; cmd_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            cmd_done = 1'b0;
            if (ARESET) begin
                cmd_ready = 1'b0; vcnt = 0; dcnt = 0;
            end else if (cmd_ready) begin
                cmd_ready = 1'b0;
                if (acc_t != 2'b11) dcnt = 3;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) cmd_done = 1'b1;
            end else if (cmd_valid && eng_en) begin
                vcnt++;
                if (vcnt == 2) begin
                    cmd_ready = 1'b1; acc_t = cmd_type; vcnt = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        ARESET = 1'b1; rd_req_valid = 1'b0; wr_req_valid = 1'b0; eng_en = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        ARESET = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n == 100) tmo(nm);
    endtask

    task automatic do_req(input bit is_rd, input logic [AW-1:0] a, input logic [1:0] et,
                          input logic [AW-1:0] ea, input string nm);
        int n;
        @(posedge clk); #1;
        if (is_rd) begin rd_req_valid = 1'b1; rd_req_addr = a; end
        else begin wr_req_valid = 1'b1; wr_req_addr = a; end
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (is_rd ? rd_req_ready : wr_req_ready) break;
        end
        if (n == 100) begin
            tmo({nm, "_ready"});
            rd_req_valid = 1'b0; wr_req_valid = 1'b0;
            return;
        end
        chk({nm, "_other_ready"}, is_rd ? wr_req_ready : rd_req_ready, 0);
        @(posedge clk); #1;
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_cmd_valid"}, cmd_valid, 1);
        chk({nm, "_cmd_type"}, cmd_type, et);
        chk({nm, "_cmd_addr"}, cmd_addr, ea);
        wait_idle({nm, "_idle"});
        chk({nm, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int n, acc, run;
        string exp_s;
        vecs[0] = '{1'b0, 28'h0001000, 2'b01, 28'h0001000};
        vecs[1] = '{1'b1, 28'h0ABCDEF, 2'b10, 28'h0ABCDEF};
        vecs[2] = '{1'b0, 28'hFFFFFFF, 2'b01, 28'hFFFFFFF};
        vecs[3] = '{1'b1, 28'h0000000, 2'b10, 28'h0000000};
        vecs[4] = '{1'b0, 28'h5A5A5A5, 2'b01, 28'h5A5A5A5};
        vecs[5] = '{1'b1, 28'h8000001, 2'b10, 28'h8000001};
        ARESET = 1'b1; init_done = 1'b0;
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        rd_req_addr = '0; wr_req_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_type", cmd_type, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_ref_owed", ref_owed, 0);
        chk("rst_overflow", ref_overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_ready", rd_req_ready, 0);
        chk("rst_wr_ready", wr_req_ready, 0);

        // no grants while init_done is low
        @(posedge clk); #1;
        ARESET = 1'b0; wr_req_valid = 1'b1; wr_req_addr = 28'h0000123;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("noinit_wr_ready", wr_req_ready, 0);
        end
        chk("noinit_busy", busy, 0);
        @(posedge clk); #1;
        wr_req_valid = 1'b0; init_done = 1'b1;

        // table of single transactions
        for (int i = 0; i < 6; i++)
            do_req(vecs[i].is_rd, vecs[i].addr, vecs[i].etype, vecs[i].eaddr, $sformatf("vec%0d", i));

        // fairness with both directions held valid
        do_reset();
        @(posedge clk); #1;
        rd_req_valid = 1'b1; rd_req_addr = 28'h0000100;
        wr_req_valid = 1'b1; wr_req_addr = 28'h0000200;
        grants.delete();
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (grants.size() >= 10) break;
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        if (n == 300) tmo("fair_grants");
        else begin
            exp_s = "RRRRWWWWRR";
            run = 1;
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("fair_grant%0d", i), grants[i], exp_s[i]);
                if (i > 0) run = (grants[i] == grants[i-1]) ? run + 1 : 1;
                chk($sformatf("fair_run%0d_le4", i), run <= 4, 1);
            end
        end
        wait_idle("fair_idle");

        // idle refresh timing and tRFC spacing
        do_reset();
        repeat (99) @(posedge clk);
        @(negedge clk);
        chk("ref_owed_before_wrap", ref_owed, 0);
        @(negedge clk);
        chk("ref_owed_after_wrap", ref_owed, 1);
        chk("ref_not_yet_valid", cmd_valid, 0);
        @(negedge clk);
        chk("ref_cmd_valid", cmd_valid, 1);
        chk("ref_cmd_type", cmd_type, 2'b11);
        chk("ref_cmd_addr", cmd_addr, 0);
        for (n = 0; n < 20; n++) begin
            if (cmd_valid && cmd_ready) break;
            @(negedge clk);
        end
        acc = cyc;
        if (n == 20) tmo("ref_accept");
        @(posedge clk); #1;
        wr_req_valid = 1'b1; wr_req_addr = 28'h0000042;
        @(negedge clk);
        chk("ref_owed_after_accept", ref_owed, 0);
        for (n = 0; n < 50; n++) begin
            if (wr_req_ready) break;
            @(negedge clk);
        end
        if (n == 50) tmo("rfc_next_grant");
        else chk("rfc_spacing_ge6", (cyc - acc) >= 6, 1);
        @(posedge clk); #1;
        wr_req_valid = 1'b0;
        wait_idle("rfc_idle");

        // urgent refresh overtakes a pending read
        do_reset();
        eng_en = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 28'h0000777;
        for (n = 0; n < 600; n++) begin
            @(negedge clk);
            if (ref_owed == 4'd4) break;
        end
        if (n == 600) tmo("urg_owed4");
        @(posedge clk); #1;
        eng_en = 1'b1;
        wait_idle("urg_idle");
        chk("urg_rd_not_ready", rd_req_ready, 0);
        @(negedge clk);
        chk("urg_ref_valid", cmd_valid, 1);
        chk("urg_ref_type", cmd_type, 2'b11);
        for (n = 0; n < 20; n++) begin
            if (cmd_valid && cmd_ready) break;
            @(negedge clk);
        end
        if (n == 20) tmo("urg_ref_accept");
        @(negedge clk);
        chk("urg_owed3", ref_owed, 3);
        for (n = 0; n < 50; n++) begin
            if (rd_req_ready) break;
            @(negedge clk);
        end
        if (n == 50) tmo("urg_rd_after_ref");
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        @(negedge clk);
        chk("urg_rd_type", cmd_type, 2'b10);
        wait_idle("urg_rd_idle");

        // refresh starvation saturates and sets sticky overflow
        do_reset();
        eng_en = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 28'h0000321;
        repeat (1000) @(negedge clk);
        chk("starve_owed8", ref_owed, 8);
        chk("starve_overflow", ref_overflow, 1);
        @(posedge clk); #1;
        eng_en = 1'b1; rd_req_valid = 1'b0;
        repeat (150) @(negedge clk);
        chk("starve_drained", ref_owed < 4'd8, 1);
        chk("starve_overflow_sticky", ref_overflow, 1);
        do_reset();
        @(negedge clk);
        chk("starve_ovf_cleared", ref_overflow, 0);
        chk("starve_owed_cleared", ref_owed, 0);

        // reset while waiting for cmd_done
        @(posedge clk); #1;
        wr_req_valid = 1'b1; wr_req_addr = 28'h0000ABC;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wr_req_ready) break;
        end
        @(posedge clk); #1;
        wr_req_valid = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) break;
        end
        if (n == 50) tmo("mid_accept");
        @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_valid_low", cmd_valid, 0);
        @(posedge clk); #1;
        ARESET = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_type", cmd_type, 0);
        chk("mid_rst_addr", cmd_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_owed", ref_owed, 0);
        @(posedge clk); #1;
        ARESET = 1'b0;
        @(posedge clk);
        do_req(1'b0, 28'h0C0FFEE, 2'b01, 28'h0C0FFEE, "post_rst_wr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
